// File: rtl/btn_press_conditioner.sv
`default_nettype none
// ============================================================================
// btn_press_conditioner
// Synchronizes, debounces and edge-qualifies four raw push-buttons into a
// one-cycle press vector plus a multi-press flag.
// Revision: 1.0
// ============================================================================
module btn_press_conditioner #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] btn_raw,
  output logic [3:0] btn,
  output logic       invalid,
  output logic       busy
);

  localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_HOLD = 1'b1
  } state_t;

  logic [3:0] r_s1;
  logic [3:0] r_s2;
  logic [3:0] w_db;
  logic       w_multi;
  state_t     r_state;

  // Two-flop synchronizer per bit; bits are not coherent with each other.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 4'b0;
      r_s2 <= 4'b0;
    end else begin
      r_s1 <= btn_raw;
      r_s2 <= r_s1;
    end
  end

  // A new level is accepted only after it has differed from the debounced
  // value for DEBOUNCE_CYCLES consecutive cycles; any agreement restarts it.
  for (genvar i = 0; i < 4; i++) begin : g_bit
    logic [CNT_W-1:0] r_cnt;
    logic             r_db;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        r_cnt <= '0;
        r_db  <= 1'b0;
      end else if (r_s2[i] == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == c_cnt_last) begin
        r_db  <= r_s2[i];
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + 1'b1;
      end
    end

    assign w_db[i] = r_db;
  end

  assign w_multi = ($countones(w_db) > 1);

  // One event per episode: IDLE fires on any debounced press, HOLD waits
  // until every debounced bit has returned to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      btn     <= 4'b0;
      invalid <= 1'b0;
      busy    <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_db != 4'b0) begin
            btn     <= w_db;
            invalid <= w_multi;
            busy    <= 1'b1;
            r_state <= ST_HOLD;
          end else begin
            btn     <= 4'b0;
            invalid <= 1'b0;
            busy    <= 1'b0;
          end
        end
        ST_HOLD: begin
          btn     <= 4'b0;
          invalid <= 1'b0;
          if (w_db == 4'b0) begin
            busy    <= 1'b0;
            r_state <= ST_IDLE;
          end else begin
            busy    <= 1'b1;
          end
        end
        default: begin
          btn     <= 4'b0;
          invalid <= 1'b0;
          busy    <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_btn_press_conditioner.sv
`default_nettype none
// Testbench for btn_press_conditioner: directed episodes plus random button
// patterns, every cycle compared against a window-based behavioural model.
module tb_btn_press_conditioner;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [3:0] btn_raw = 4'b0;
  logic [3:0] btn;
  logic       invalid;
  logic       busy;

  btn_press_conditioner #(.DEBOUNCE_CYCLES(N), .CNT_W(16)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .btn_raw (btn_raw),
    .btn     (btn),
    .invalid (invalid),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Reference model: raw values in flight through the synchronizer, and the
  // last N synchronized samples seen by the debouncer.
  logic [3:0] m_pipe[$];
  logic [3:0] m_win[$];
  logic [3:0] m_db;
  logic       m_hold;
  logic [3:0] m_btn;
  logic       m_inv;

  int         cyc = 0;
  int         n_pulse = 0;
  logic [3:0] last_pulse = 4'b0;
  logic       last_inv = 1'b0;
  int         pulse_cyc = 0;
  int         busy_fall_cyc = 0;
  logic       prev_busy = 1'b0;
  logic       busy_seen = 1'b0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pipe = {4'b0, 4'b0};
    m_win.delete();
    for (int k = 0; k < N; k++) m_win.push_back(4'b0);
    m_db = 4'b0; m_hold = 1'b0; m_btn = 4'b0; m_inv = 1'b0;
    prev_busy = 1'b0;
  endtask

  // One clock edge of the specified behaviour, using pre-edge values.
  task automatic model_step();
    logic [3:0] s2;
    logic [3:0] db_old;
    logic       all_diff;
    s2     = m_pipe[0];
    db_old = m_db;
    void'(m_pipe.pop_front());
    m_pipe.push_back(btn_raw);
    void'(m_win.pop_front());
    m_win.push_back(s2);
    for (int b = 0; b < 4; b++) begin
      all_diff = 1'b1;
      foreach (m_win[k]) if (m_win[k][b] == db_old[b]) all_diff = 1'b0;
      if (all_diff) m_db[b] = ~db_old[b];
    end
    if (!m_hold) begin
      m_btn = db_old;
      m_inv = ($countones(db_old) > 1);
      m_hold = (db_old != 4'b0);
    end else begin
      m_btn = 4'b0;
      m_inv = 1'b0;
      if (db_old == 4'b0) m_hold = 1'b0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    cyc++;
    #1;
    chk("btn", 32'(btn), 32'(m_btn));
    chk("invalid", 32'(invalid), 32'(m_inv));
    chk("busy", 32'(busy), 32'(m_hold));
    if (btn != 4'b0) begin
      n_pulse++;
      last_pulse = btn;
      last_inv   = invalid;
      pulse_cyc  = cyc;
    end
    if (busy) busy_seen = 1'b1;
    if (prev_busy && !busy) busy_fall_cyc = cyc;
    prev_busy = busy;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  // Asserts reset at the current (non-edge) time, holds it for some edges,
  // and releases it on a falling edge.
  task automatic apply_reset(input int edges);
    rst_n = 1'b0;
    #1;
    chk("rst_btn", 32'(btn), 32'h0);
    chk("rst_invalid", 32'(invalid), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    model_reset();
    for (int k = 0; k < edges; k++) begin
      @(posedge clk);
      #1;
      chk("rst_hold_btn", 32'(btn), 32'h0);
      chk("rst_hold_busy", 32'(busy), 32'h0);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic wait_idle(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (!busy && m_db == 4'b0 && m_pipe[0] == 4'b0 && m_pipe[1] == 4'b0) break;
      tick();
    end
    chk("idle_timeout", 32'(busy), 32'h0);
  endtask

  task automatic wait_busy(input int budget);
    for (int k = 0; k < budget; k++) begin
      if (busy) break;
      tick();
    end
    chk("busy_timeout", 32'(busy), 32'h1);
  endtask

  initial begin
    int start;
    int rel;
    int p0;
    #3;
    apply_reset(2);
    tick();
    chk("post_reset_btn", 32'(btn), 32'h0);

    // Single press of bit 1, pulse 7 edges after the first sample.
    start = cyc;
    p0 = n_pulse;
    btn_raw = 4'b0010;
    ticks(20);
    chk("t1_pulses", 32'(n_pulse - p0), 32'd1);
    chk("t1_val", 32'(last_pulse), 32'h2);
    chk("t1_inv", 32'(last_inv), 32'h0);
    chk("t1_cyc", 32'(pulse_cyc), 32'(start + 7));
    rel = cyc;
    btn_raw = 4'b0;
    wait_idle(30);
    chk("t1_busy_fall", 32'(busy_fall_cyc), 32'(rel + 7));

    // Three-cycle glitch on bit 1 is filtered out.
    p0 = n_pulse;
    busy_seen = 1'b0;
    btn_raw = 4'b0010;
    ticks(3);
    btn_raw = 4'b0;
    ticks(12);
    chk("t2_pulses", 32'(n_pulse - p0), 32'd0);
    chk("t2_busy_seen", 32'(busy_seen), 32'h0);

    // Simultaneous press of bits 0 and 3.
    p0 = n_pulse;
    btn_raw = 4'b1001;
    ticks(15);
    chk("t3_pulses", 32'(n_pulse - p0), 32'd1);
    chk("t3_val", 32'(last_pulse), 32'h9);
    chk("t3_inv", 32'(last_inv), 32'h1);
    btn_raw = 4'b0;
    wait_idle(30);

    // Staggered press: first button wins, the late one is ignored.
    p0 = n_pulse;
    btn_raw = 4'b0001;
    ticks(2);
    btn_raw = 4'b0101;
    ticks(20);
    btn_raw = 4'b0;
    wait_idle(30);
    chk("t4_pulses", 32'(n_pulse - p0), 32'd1);
    chk("t4_val", 32'(last_pulse), 32'h1);
    chk("t4_inv", 32'(last_inv), 32'h0);
    btn_raw = 4'b0100;
    ticks(12);
    chk("t4_repress_pulses", 32'(n_pulse - p0), 32'd2);
    chk("t4_repress_val", 32'(last_pulse), 32'h4);
    btn_raw = 4'b0;
    wait_idle(30);

    // Back-to-back episodes on bit 3.
    p0 = n_pulse;
    btn_raw = 4'b1000;
    ticks(10);
    btn_raw = 4'b0;
    wait_idle(30);
    btn_raw = 4'b1000;
    ticks(10);
    chk("t5_pulses", 32'(n_pulse - p0), 32'd2);
    chk("t5_val", 32'(last_pulse), 32'h8);
    btn_raw = 4'b0;
    wait_idle(30);

    // Reset in HOLD with bit 2 still held re-qualifies from scratch.
    btn_raw = 4'b0100;
    wait_busy(20);
    ticks(3);
    #2;
    apply_reset(2);
    start = cyc;
    p0 = n_pulse;
    ticks(12);
    chk("t6_pulses", 32'(n_pulse - p0), 32'd1);
    chk("t6_val", 32'(last_pulse), 32'h4);
    chk("t6_cyc", 32'(pulse_cyc), 32'(start + 7));
    btn_raw = 4'b0;
    wait_idle(30);

    // Random button patterns of random duration, glitches included.
    for (int r = 0; r < 80; r++) begin
      btn_raw = 4'($urandom_range(0, 15));
      ticks($urandom_range(1, 10));
    end
    btn_raw = 4'b0;
    wait_idle(40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
